// File: rtl/eddsa_seq_ctrl_if.sv
// eddsa_seq_ctrl_if: EdDSA accelerator command bus.
// master = sequencer side (drives control/address/write data),
// slave  = accelerator wrapper side (returns read data and completion flags).
interface eddsa_seq_ctrl_if #(
    parameter int unsigned WIDTH = 64
);
    logic [3:0]       itf_control;
    logic [WIDTH-1:0] itf_address;
    logic [WIDTH-1:0] itf_data_in;
    logic [WIDTH-1:0] itf_data_out;
    logic             itf_end_op;
    logic             itf_error;

    modport master (
        output itf_control,
        output itf_address,
        output itf_data_in,
        input  itf_data_out,
        input  itf_end_op,
        input  itf_error
    );

    modport slave (
        input  itf_control,
        input  itf_address,
        input  itf_data_in,
        output itf_data_out,
        output itf_end_op,
        output itf_error
    );
endinterface

// File: rtl/eddsa_seq_ctrl.sv
// eddsa_seq_ctrl: stages operand words from the host, then drives the EdDSA
// accelerator bus through reset, op-select load, operand loads, start, wait
// for completion and result readback.
// Optional build macro EDDSA_SEQ_TIMEOUT_EN adds a WAIT watchdog that aborts
// with status TIMEOUT after TIMEOUT_CYCLES cycles.
module eddsa_seq_ctrl #(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned N_WORDS        = 34,
    parameter int unsigned RD_BASE        = 26,
    parameter int unsigned RD_WORDS       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [3:0]       op,
    input  logic             wr_en,
    input  logic [5:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic             res_valid,
    output logic [3:0]       res_idx,
    output logic [WIDTH-1:0] res_data,
    eddsa_seq_ctrl_if.master itf
);

    localparam logic [3:0] CTL_RST   = 4'b0111;
    localparam logic [3:0] CTL_LOAD  = 4'b0101;
    localparam logic [3:0] CTL_IDLE  = 4'b0001;
    localparam logic [3:0] CTL_START = 4'b0000;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ITF_ERR = 2'b01;
    localparam logic [1:0] ST_TMO     = 2'b10;
    localparam logic [1:0] ST_BAD_OP  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ITF_RST,
        S_LD_OP,
        S_LD_ADDR,
        S_LD_DATA,
        S_START,
        S_WAIT,
        S_RD_ADDR,
        S_RD_DATA,
        S_FIN,
        S_TMO_RST
    } state_t;

    state_t           state_q, state_n;
    logic [3:0]       op_q, op_n;
    logic             ph_q, ph_n;
    logic [5:0]       idx_q, idx_n;
    logic [3:0]       rdk_q, rdk_n;
    logic [3:0]       ctl_q, ctl_n;
    logic [WIDTH-1:0] addr_q, addr_n;
    logic [WIDTH-1:0] din_q, din_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic [1:0]       status_q, status_n;
    logic             rv_q, rv_n;
    logic [3:0]       ridx_q, ridx_n;
    logic [WIDTH-1:0] rdata_q, rdata_n;
    logic             load_adv;

    logic [WIDTH-1:0] word_mem [N_WORDS];
    logic [N_WORDS-1:0] vld_q;
    logic             wr_ok;
    logic             scan_found;
    logic [5:0]       scan_idx;

`ifdef EDDSA_SEQ_TIMEOUT_EN
    logic [31:0]      tmo_q, tmo_n;
`else
    // Timeout depth only matters when the watchdog is compiled in.
    logic [31:0]      unused_tmo;
    assign unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

    assign wr_ok = wr_en && !busy_q && (wr_addr != 6'd0) && (32'(wr_addr) < N_WORDS);

    assign busy             = busy_q;
    assign done             = done_q;
    assign status           = status_q;
    assign res_valid        = rv_q;
    assign res_idx          = ridx_q;
    assign res_data         = rdata_q;
    assign itf.itf_control  = ctl_q;
    assign itf.itf_address  = addr_q;
    assign itf.itf_data_in  = din_q;

    // Operand valid bits: clr beats a same-cycle write; both ignored while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (!busy_q) begin
            if (clr) begin
                vld_q <= '0;
            end else if (wr_ok) begin
                vld_q[wr_addr] <= 1'b1;
            end
        end
    end

    // Operand word storage (no reset needed, qualified by the valid bits).
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            word_mem[wr_addr] <= wr_data;
        end
    end

    // Lowest valid index above the current one; skipped entries cost no cycles.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < N_WORDS; i++) begin
            if (!scan_found && vld_q[i] && (state_q == S_LD_OP || i > 32'(idx_q))) begin
                scan_found = 1'b1;
                scan_idx   = 6'(i);
            end
        end
    end

    // Next-state and next-output logic; outputs are registered with the state.
    always_comb begin
        state_n  = state_q;
        op_n     = op_q;
        ph_n     = 1'b0;
        idx_n    = idx_q;
        rdk_n    = rdk_q;
        ctl_n    = ctl_q;
        addr_n   = addr_q;
        din_n    = din_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        status_n = status_q;
        rv_n     = 1'b0;
        ridx_n   = ridx_q;
        rdata_n  = rdata_q;
        load_adv = 1'b0;
`ifdef EDDSA_SEQ_TIMEOUT_EN
        tmo_n    = tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (op == 4'd0) begin
                        status_n = ST_BAD_OP;
                        state_n  = S_FIN;
                    end else begin
                        op_n     = op;
                        busy_n   = 1'b1;
                        status_n = ST_OK;
                        ctl_n    = CTL_RST;
                        state_n  = S_ITF_RST;
                    end
                end
            end
            S_ITF_RST: begin
                ctl_n   = CTL_LOAD;
                addr_n  = '0;
                din_n   = {{(WIDTH-4){1'b0}}, op_q};
                state_n = S_LD_OP;
            end
            S_LD_OP: begin
                if (!ph_q) begin
                    ph_n = 1'b1;
                end else begin
                    load_adv = 1'b1;
                end
            end
            S_LD_ADDR: begin
                din_n   = word_mem[idx_q];
                state_n = S_LD_DATA;
            end
            S_LD_DATA: begin
                load_adv = 1'b1;
            end
            S_START: begin
`ifdef EDDSA_SEQ_TIMEOUT_EN
                tmo_n = '0;
`endif
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (itf.itf_error) begin
                    status_n = ST_ITF_ERR;
                    state_n  = S_FIN;
                end else if (itf.itf_end_op) begin
                    ctl_n   = CTL_IDLE;
                    addr_n  = WIDTH'(RD_BASE);
                    rdk_n   = '0;
                    state_n = S_RD_ADDR;
                end
`ifdef EDDSA_SEQ_TIMEOUT_EN
                else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    status_n = ST_TMO;
                    ctl_n    = CTL_RST;
                    state_n  = S_TMO_RST;
                end else begin
                    tmo_n = tmo_q + 32'd1;
                end
`endif
            end
            S_RD_ADDR: begin
                state_n = S_RD_DATA;
            end
            S_RD_DATA: begin
                rv_n    = 1'b1;
                ridx_n  = rdk_q;
                rdata_n = itf.itf_data_out;
                if (32'(rdk_q) == RD_WORDS - 1) begin
                    state_n = S_FIN;
                end else begin
                    rdk_n   = rdk_q + 4'd1;
                    addr_n  = WIDTH'(RD_BASE) + WIDTH'(rdk_q) + WIDTH'(1);
                    state_n = S_RD_ADDR;
                end
            end
            S_TMO_RST: begin
                state_n = S_FIN;
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // LD_OP's second cycle and every LD_DATA share the same exit:
        // jump to the next valid entry, or straight to START if none is left.
        if (load_adv) begin
            if (scan_found) begin
                idx_n   = scan_idx;
                addr_n  = WIDTH'(scan_idx);
                state_n = S_LD_ADDR;
            end else begin
                ctl_n   = CTL_START;
                state_n = S_START;
            end
        end

        // Every path into FIN (normal, error, timeout, bad op) looks the same on the bus.
        if (state_n == S_FIN) begin
            ctl_n  = CTL_IDLE;
            addr_n = '0;
            busy_n = 1'b0;
            done_n = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            ph_q     <= 1'b0;
            idx_q    <= '0;
            rdk_q    <= '0;
            ctl_q    <= CTL_IDLE;
            addr_q   <= '0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= ST_OK;
            rv_q     <= 1'b0;
            ridx_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_n;
            op_q     <= op_n;
            ph_q     <= ph_n;
            idx_q    <= idx_n;
            rdk_q    <= rdk_n;
            ctl_q    <= ctl_n;
            addr_q   <= addr_n;
            din_q    <= din_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            status_q <= status_n;
            rv_q     <= rv_n;
            ridx_q   <= ridx_n;
            rdata_q  <= rdata_n;
        end
    end

`ifdef EDDSA_SEQ_TIMEOUT_EN
    // Watchdog counter for the WAIT state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_n;
        end
    end
`endif

endmodule
